// File: rtl/params_pkg.sv
// -----------------------------------------------------------------------------
// params_pkg
// Shared constants and types for the writeback arbiter slice.
//   REGISTER_WIDTH   : architectural register index width
//   WB_STARVE_LIMIT  : default denied-cycle count before a source is promoted
//   wb_src_e         : identifies which pipe produced the held writeback result
//   wb_req_t         : one writeback payload at the default widths
//   sat_inc32        : saturating 32-bit increment used by the statistics counters
// -----------------------------------------------------------------------------
package params_pkg;

    localparam int REGISTER_WIDTH   = 5;
    localparam int WB_DATA_WIDTH    = 32;
    localparam int WB_ROB_IDX_WIDTH = 4;
    localparam int WB_STARVE_LIMIT  = 3;
    localparam int WB_WAIT_CNT_W    = 4;

    typedef enum logic [1:0] {
        WB_SRC_NONE,
        WB_SRC_ALU,
        WB_SRC_MEM,
        WB_SRC_EX
    } wb_src_e;

    // 'reg' is a keyword, so the destination register field is reg_idx.
    typedef struct packed {
        logic [REGISTER_WIDTH-1:0]   reg_idx;
        logic [WB_DATA_WIDTH-1:0]    data;
        logic [WB_ROB_IDX_WIDTH-1:0] rob_idx;
    } wb_req_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == '1) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_arbiter_if
// Bundles the three producer request/payload/grant groups and the writeback
// stage outputs of wb_arbiter.
//   slave  : the arbiter view (takes requests and ROB ready, drives grants and
//            the writeback stage)
//   master : the surrounding pipeline view (drives requests and ROB ready)
// -----------------------------------------------------------------------------
interface wb_arbiter_if #(
    parameter int REGISTER_WIDTH = params_pkg::REGISTER_WIDTH,
    parameter int DATA_WIDTH     = 32,
    parameter int ROB_IDX_WIDTH  = 4
) ();
    import params_pkg::*;

    logic                      alu_wb_req_i;
    logic [REGISTER_WIDTH-1:0] alu_wb_reg_i;
    logic [DATA_WIDTH-1:0]     alu_wb_data_i;
    logic [ROB_IDX_WIDTH-1:0]  alu_wb_rob_idx_i;
    logic                      alu_wb_gnt_o;

    logic                      mem_wb_req_i;
    logic [REGISTER_WIDTH-1:0] mem_wb_reg_i;
    logic [DATA_WIDTH-1:0]     mem_wb_data_i;
    logic [ROB_IDX_WIDTH-1:0]  mem_wb_rob_idx_i;
    logic                      mem_wb_gnt_o;

    logic                      ex_wb_req_i;
    logic [REGISTER_WIDTH-1:0] ex_wb_reg_i;
    logic [DATA_WIDTH-1:0]     ex_wb_data_i;
    logic [ROB_IDX_WIDTH-1:0]  ex_wb_rob_idx_i;
    logic                      ex_wb_gnt_o;

    logic                      wb_ready_i;
    logic                      wb_valid_o;
    logic [REGISTER_WIDTH-1:0] wb_reg_o;
    logic [DATA_WIDTH-1:0]     wb_data_o;
    logic [ROB_IDX_WIDTH-1:0]  wb_rob_idx_o;
    wb_src_e                   wb_src_o;

    modport slave (
        input  alu_wb_req_i, alu_wb_reg_i, alu_wb_data_i, alu_wb_rob_idx_i,
        input  mem_wb_req_i, mem_wb_reg_i, mem_wb_data_i, mem_wb_rob_idx_i,
        input  ex_wb_req_i,  ex_wb_reg_i,  ex_wb_data_i,  ex_wb_rob_idx_i,
        input  wb_ready_i,
        output alu_wb_gnt_o, mem_wb_gnt_o, ex_wb_gnt_o,
        output wb_valid_o, wb_reg_o, wb_data_o, wb_rob_idx_o, wb_src_o
    );

    modport master (
        output alu_wb_req_i, alu_wb_reg_i, alu_wb_data_i, alu_wb_rob_idx_i,
        output mem_wb_req_i, mem_wb_reg_i, mem_wb_data_i, mem_wb_rob_idx_i,
        output ex_wb_req_i,  ex_wb_reg_i,  ex_wb_data_i,  ex_wb_rob_idx_i,
        output wb_ready_i,
        input  alu_wb_gnt_o, mem_wb_gnt_o, ex_wb_gnt_o,
        input  wb_valid_o, wb_reg_o, wb_data_o, wb_rob_idx_o, wb_src_o
    );

endinterface

// File: rtl/wb_starve_counter.sv
// -----------------------------------------------------------------------------
// wb_starve_counter
// Per-source wait counter. Counts consecutive cycles in which the source
// requested, the writeback stage could accept, and another source won.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   req_i          : source is requesting
//   gnt_i          : source was granted this cycle
//   can_accept_i   : writeback stage can take a result this cycle
//   starved_o      : counter has reached STARVE_LIMIT
// -----------------------------------------------------------------------------
module wb_starve_counter #(
    parameter int STARVE_LIMIT = params_pkg::WB_STARVE_LIMIT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    input  logic gnt_i,
    input  logic can_accept_i,
    output logic starved_o
);
    import params_pkg::*;

    localparam logic [WB_WAIT_CNT_W-1:0] LIMIT = WB_WAIT_CNT_W'(STARVE_LIMIT);

    logic [WB_WAIT_CNT_W-1:0] cnt_q;
    logic [WB_WAIT_CNT_W-1:0] cnt_d;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (!req_i || gnt_i) begin
            cnt_d = '0;
        end else if (can_accept_i && (cnt_q != LIMIT)) begin
            // Backpressure (can_accept_i=0) holds the count: it is not a lost arbitration.
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starved_o = (cnt_q == LIMIT);

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Arbitrates the single writeback port among the ALU, MEM and EX pipes and
// registers the winner into a one-entry writeback stage.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : per-source req/reg/data/rob_idx in, per-source grant out,
//                   wb_ready_i in, wb_valid/reg/data/rob_idx/src out
// Priority is EX > MEM > ALU; a source denied STARVE_LIMIT cycles in a row is
// starved, and starved requesters win over all others in the order ALU > MEM > EX.
// Optional feature macro WB_ARB_STATS_EN adds saturating grant counters per
// source and a conflict-cycle counter.
// -----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int REGISTER_WIDTH = params_pkg::REGISTER_WIDTH,
    parameter int DATA_WIDTH     = 32,
    parameter int ROB_IDX_WIDTH  = 4,
    parameter int STARVE_LIMIT   = params_pkg::WB_STARVE_LIMIT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    wb_arbiter_if.slave bus
`ifdef WB_ARB_STATS_EN
    ,
    output logic [31:0] alu_grant_cnt_o,
    output logic [31:0] mem_grant_cnt_o,
    output logic [31:0] ex_grant_cnt_o,
    output logic [31:0] conflict_cnt_o
`endif
);
    import params_pkg::*;

    logic                      valid_q,   valid_d;
    logic [REGISTER_WIDTH-1:0] reg_q,     reg_d;
    logic [DATA_WIDTH-1:0]     data_q,    data_d;
    logic [ROB_IDX_WIDTH-1:0]  rob_idx_q, rob_idx_d;
    wb_src_e                   src_q,     src_d;

    logic can_accept;
    logic alu_starved, mem_starved, ex_starved;
    logic alu_st_req,  mem_st_req,  ex_st_req;
    logic alu_gnt,     mem_gnt,     ex_gnt;

    // Gated by reset so grants read 0 while the block is held in reset.
    assign can_accept = rst_ni && (!valid_q || bus.wb_ready_i);

    assign alu_st_req = bus.alu_wb_req_i && alu_starved;
    assign mem_st_req = bus.mem_wb_req_i && mem_starved;
    assign ex_st_req  = bus.ex_wb_req_i  && ex_starved;

    always_comb begin
        alu_gnt = 1'b0;
        mem_gnt = 1'b0;
        ex_gnt  = 1'b0;
        if (can_accept) begin
            if (alu_st_req || mem_st_req || ex_st_req) begin
                // Starved order is inverted: the cheapest-to-stall pipe is the one that starves.
                if (alu_st_req)      alu_gnt = 1'b1;
                else if (mem_st_req) mem_gnt = 1'b1;
                else                 ex_gnt  = 1'b1;
            end else begin
                if (bus.ex_wb_req_i)       ex_gnt  = 1'b1;
                else if (bus.mem_wb_req_i) mem_gnt = 1'b1;
                else if (bus.alu_wb_req_i) alu_gnt = 1'b1;
            end
        end
    end

    wb_starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_alu_starve (
        .clk_i, .rst_ni, .req_i(bus.alu_wb_req_i), .gnt_i(alu_gnt),
        .can_accept_i(can_accept), .starved_o(alu_starved)
    );
    wb_starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_mem_starve (
        .clk_i, .rst_ni, .req_i(bus.mem_wb_req_i), .gnt_i(mem_gnt),
        .can_accept_i(can_accept), .starved_o(mem_starved)
    );
    wb_starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_ex_starve (
        .clk_i, .rst_ni, .req_i(bus.ex_wb_req_i), .gnt_i(ex_gnt),
        .can_accept_i(can_accept), .starved_o(ex_starved)
    );

    // Writeback stage: load on grant, drain on ready, otherwise hold.
    always_comb begin
        valid_d   = valid_q;
        reg_d     = reg_q;
        data_d    = data_q;
        rob_idx_d = rob_idx_q;
        src_d     = src_q;
        if (ex_gnt) begin
            valid_d   = 1'b1;
            reg_d     = bus.ex_wb_reg_i;
            data_d    = bus.ex_wb_data_i;
            rob_idx_d = bus.ex_wb_rob_idx_i;
            src_d     = WB_SRC_EX;
        end else if (mem_gnt) begin
            valid_d   = 1'b1;
            reg_d     = bus.mem_wb_reg_i;
            data_d    = bus.mem_wb_data_i;
            rob_idx_d = bus.mem_wb_rob_idx_i;
            src_d     = WB_SRC_MEM;
        end else if (alu_gnt) begin
            valid_d   = 1'b1;
            reg_d     = bus.alu_wb_reg_i;
            data_d    = bus.alu_wb_data_i;
            rob_idx_d = bus.alu_wb_rob_idx_i;
            src_d     = WB_SRC_ALU;
        end else if (bus.wb_ready_i) begin
            valid_d   = 1'b0;
        end
    end

    // NOTE: the payload flops are reset as well as valid, so the outputs read a defined 0 after reset rather than stale data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q   <= 1'b0;
            reg_q     <= '0;
            data_q    <= '0;
            rob_idx_q <= '0;
            src_q     <= WB_SRC_NONE;
        end else begin
            valid_q   <= valid_d;
            reg_q     <= reg_d;
            data_q    <= data_d;
            rob_idx_q <= rob_idx_d;
            src_q     <= src_d;
        end
    end

    assign bus.alu_wb_gnt_o = alu_gnt;
    assign bus.mem_wb_gnt_o = mem_gnt;
    assign bus.ex_wb_gnt_o  = ex_gnt;
    assign bus.wb_valid_o   = valid_q;
    assign bus.wb_reg_o     = reg_q;
    assign bus.wb_data_o    = data_q;
    assign bus.wb_rob_idx_o = rob_idx_q;
    assign bus.wb_src_o     = src_q;

`ifdef WB_ARB_STATS_EN
    logic [31:0] alu_cnt_q, alu_cnt_d;
    logic [31:0] mem_cnt_q, mem_cnt_d;
    logic [31:0] ex_cnt_q,  ex_cnt_d;
    logic [31:0] conf_cnt_q, conf_cnt_d;
    logic        conflict;

    assign conflict = can_accept &&
                      ((bus.alu_wb_req_i && bus.mem_wb_req_i) ||
                       (bus.alu_wb_req_i && bus.ex_wb_req_i)  ||
                       (bus.mem_wb_req_i && bus.ex_wb_req_i));

    always_comb begin
        alu_cnt_d  = alu_gnt  ? sat_inc32(alu_cnt_q)  : alu_cnt_q;
        mem_cnt_d  = mem_gnt  ? sat_inc32(mem_cnt_q)  : mem_cnt_q;
        ex_cnt_d   = ex_gnt   ? sat_inc32(ex_cnt_q)   : ex_cnt_q;
        conf_cnt_d = conflict ? sat_inc32(conf_cnt_q) : conf_cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alu_cnt_q  <= '0;
            mem_cnt_q  <= '0;
            ex_cnt_q   <= '0;
            conf_cnt_q <= '0;
        end else begin
            alu_cnt_q  <= alu_cnt_d;
            mem_cnt_q  <= mem_cnt_d;
            ex_cnt_q   <= ex_cnt_d;
            conf_cnt_q <= conf_cnt_d;
        end
    end

    assign alu_grant_cnt_o = alu_cnt_q;
    assign mem_grant_cnt_o = mem_cnt_q;
    assign ex_grant_cnt_o  = ex_cnt_q;
    assign conflict_cnt_o  = conf_cnt_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Directed testbench for wb_arbiter (STARVE_LIMIT = 3). Inputs change 1 ns
// after the rising edge; combinational grants are sampled 1 ns later and the
// registered stage is sampled after the following edge.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;
    import params_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    wb_arbiter_if bus ();

`ifdef WB_ARB_STATS_EN
    logic [31:0] alu_grant_cnt, mem_grant_cnt, ex_grant_cnt, conflict_cnt;
`endif

    wb_arbiter #(
        .REGISTER_WIDTH(5),
        .DATA_WIDTH    (32),
        .ROB_IDX_WIDTH (4),
        .STARVE_LIMIT  (3)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
`ifdef WB_ARB_STATS_EN
        ,
        .alu_grant_cnt_o(alu_grant_cnt),
        .mem_grant_cnt_o(mem_grant_cnt),
        .ex_grant_cnt_o (ex_grant_cnt),
        .conflict_cnt_o (conflict_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input wb_src_e src, input logic req, input wb_req_t p);
        case (src)
            WB_SRC_ALU: begin
                bus.alu_wb_req_i = req; bus.alu_wb_reg_i = p.reg_idx;
                bus.alu_wb_data_i = p.data; bus.alu_wb_rob_idx_i = p.rob_idx;
            end
            WB_SRC_MEM: begin
                bus.mem_wb_req_i = req; bus.mem_wb_reg_i = p.reg_idx;
                bus.mem_wb_data_i = p.data; bus.mem_wb_rob_idx_i = p.rob_idx;
            end
            WB_SRC_EX: begin
                bus.ex_wb_req_i = req; bus.ex_wb_reg_i = p.reg_idx;
                bus.ex_wb_data_i = p.data; bus.ex_wb_rob_idx_i = p.rob_idx;
            end
            default: ;
        endcase
    endtask

    task automatic clear_reqs();
        bus.alu_wb_req_i = 1'b0;
        bus.mem_wb_req_i = 1'b0;
        bus.ex_wb_req_i  = 1'b0;
    endtask

    // Expected grant vector is {alu, mem, ex}.
    task automatic check_gnt(input string tag, input logic [2:0] exp);
        check(tag, {bus.alu_wb_gnt_o, bus.mem_wb_gnt_o, bus.ex_wb_gnt_o}, exp);
    endtask

    task automatic check_stage(input string tag, input wb_src_e src, input wb_req_t p);
        check({tag, "_valid"}, bus.wb_valid_o, 1'b1);
        check({tag, "_src"},   bus.wb_src_o, src);
        check({tag, "_reg"},   bus.wb_reg_o, p.reg_idx);
        check({tag, "_data"},  bus.wb_data_o, p.data);
        check({tag, "_rob"},   bus.wb_rob_idx_o, p.rob_idx);
    endtask

    wb_req_t p_alu  = '{reg_idx: 5'd5,  data: 32'hDEAD_BEEF, rob_idx: 4'd3};
    wb_req_t p_alu2 = '{reg_idx: 5'd0,  data: 32'h0000_0A1A, rob_idx: 4'd7};
    wb_req_t p_mem  = '{reg_idx: 5'd12, data: 32'h1234_5678, rob_idx: 4'd9};
    wb_req_t p_ex   = '{reg_idx: 5'd31, data: 32'hCAFE_F00D, rob_idx: 4'd15};

    initial begin
        rst_n = 1'b0;
        bus.wb_ready_i = 1'b0;
        clear_reqs();
        drive(WB_SRC_ALU, 1'b0, '0);
        drive(WB_SRC_MEM, 1'b0, '0);
        drive(WB_SRC_EX,  1'b0, '0);

        // Reset state
        #12;
        check("rst_valid", bus.wb_valid_o, 1'b0);
        check("rst_reg",   bus.wb_reg_o, 5'd0);
        check("rst_data",  bus.wb_data_o, 32'd0);
        check("rst_rob",   bus.wb_rob_idx_o, 4'd0);
        check("rst_src",   bus.wb_src_o, WB_SRC_NONE);
        check_gnt("rst_gnt", 3'b000);
        tick();
        rst_n = 1'b1;

        // Single ALU request: grant now, stage loaded next cycle, then drains
        bus.wb_ready_i = 1'b1;
        drive(WB_SRC_ALU, 1'b1, p_alu);
        #1 check_gnt("single_gnt", 3'b100);
        tick();
        clear_reqs();
        #1 check_stage("single_wb", WB_SRC_ALU, p_alu);
        check_gnt("single_idle", 3'b000);
        tick();
        check("single_drain", bus.wb_valid_o, 1'b0);

        // All three requesting: EX, then MEM, then ALU (x0 write still forwarded)
        drive(WB_SRC_EX,  1'b1, p_ex);
        drive(WB_SRC_MEM, 1'b1, p_mem);
        drive(WB_SRC_ALU, 1'b1, p_alu2);
        #1 check_gnt("all3_ex", 3'b001);
        tick();
        bus.ex_wb_req_i = 1'b0;
        #1 check_stage("all3_wb_ex", WB_SRC_EX, p_ex);
        check_gnt("all3_mem", 3'b010);
        tick();
        bus.mem_wb_req_i = 1'b0;
        #1 check_stage("all3_wb_mem", WB_SRC_MEM, p_mem);
        check_gnt("all3_alu", 3'b100);
        tick();
        clear_reqs();
        #1 check_stage("all3_wb_alu_x0", WB_SRC_ALU, p_alu2);
        tick();

        // Starvation: ALU denied 3 cycles by EX, granted on the 4th
        drive(WB_SRC_ALU, 1'b1, p_alu);
        drive(WB_SRC_EX,  1'b1, p_ex);
        for (int i = 0; i < 3; i++) begin
            #1 check_gnt($sformatf("starve_ex_%0d", i), 3'b001);
            tick();
        end
        #1 check_gnt("starve_alu", 3'b100);
        tick();
        clear_reqs();
        #1 check_stage("starve_wb", WB_SRC_ALU, p_alu);
        tick();

        // Backpressure: fill stage with ready=0, then ALU waits 10 cycles
        bus.wb_ready_i = 1'b0;
        drive(WB_SRC_MEM, 1'b1, p_mem);
        #1 check_gnt("bp_fill", 3'b010);
        tick();
        clear_reqs();
        drive(WB_SRC_ALU, 1'b1, p_alu);
        for (int i = 0; i < 10; i++) begin
            #1 check_gnt($sformatf("bp_hold_%0d", i), 3'b000);
            tick();
        end
        check_stage("bp_held", WB_SRC_MEM, p_mem);
        bus.wb_ready_i = 1'b1;
        #1 check_gnt("bp_release_alu", 3'b100);
        tick();
        bus.wb_ready_i = 1'b0;
        clear_reqs();
        #1 check_stage("bp_reload", WB_SRC_ALU, p_alu);
        // ALU+EX under backpressure: ALU must not become starved while blocked
        drive(WB_SRC_ALU, 1'b1, p_alu);
        drive(WB_SRC_EX,  1'b1, p_ex);
        for (int i = 0; i < 5; i++) tick();
        check_gnt("bp2_hold", 3'b000);
        bus.wb_ready_i = 1'b1;
        #1 check_gnt("bp2_no_starve", 3'b001);
        tick();
        clear_reqs();
        tick();

        // Async reset mid-stream with ALU already starved
        drive(WB_SRC_ALU, 1'b1, p_alu);
        drive(WB_SRC_EX,  1'b1, p_ex);
        for (int i = 0; i < 3; i++) tick();
        check("pre_rst_valid", bus.wb_valid_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.wb_valid_o, 1'b0);
        check("mid_rst_src",   bus.wb_src_o, WB_SRC_NONE);
        check("mid_rst_data",  bus.wb_data_o, 32'd0);
        check_gnt("mid_rst_gnt", 3'b000);
        tick();
        rst_n = 1'b1;
        #1 check_gnt("post_rst_ex1", 3'b001);
        tick();
        #1 check_gnt("post_rst_ex2", 3'b001);
        tick();
        bus.ex_wb_req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 check_gnt($sformatf("post_rst_alu_%0d", i), 3'b100);
            tick();
        end
        clear_reqs();
        #1 check_stage("post_rst_wb", WB_SRC_ALU, p_alu);
        tick();
        check("final_drain", bus.wb_valid_o, 1'b0);

`ifdef WB_ARB_STATS_EN
        // Since the last reset: EX x2 and ALU x4 grants, 2 conflict cycles
        check("stat_alu",  alu_grant_cnt, 32'd4);
        check("stat_ex",   ex_grant_cnt,  32'd2);
        check("stat_mem",  mem_grant_cnt, 32'd0);
        check("stat_conf", conflict_cnt,  32'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
